// File: rtl/sdio_cmd_responder.sv
// Card-side SD/SDIO CMD line responder: receives 48-bit host commands with CRC7
// checking, then returns a 48-bit response after an NCR gap.
//
// state    | meaning
// IDLE     | line released, watching for a start bit
// RX       | shifting in the remaining 47 command bits, then one evaluation cycle
// WAIT_RSP | rsp_ready high, waiting for the response handshake or timeout
// GAP      | NCR cycles of released line before the response
// TX       | driving the 48 response bits, then releasing the line
module sdio_cmd_responder #(
  parameter int NCR         = 2,
  parameter int RSP_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cmdi,
  output logic        cmdo,
  output logic        cmdtn,
  output logic        cmd_valid,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  output logic        cmd_err,
  output logic        rsp_ready,
  input  logic        rsp_valid,
  input  logic        rsp_skip,
  input  logic        rsp_nocrc,
  input  logic [5:0]  rsp_index,
  input  logic [31:0] rsp_arg
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RX       = 3'd1;
  localparam logic [2:0] S_WAIT_RSP = 3'd2;
  localparam logic [2:0] S_GAP      = 3'd3;
  localparam logic [2:0] S_TX       = 3'd4;

  localparam int TMAX = (RSP_TIMEOUT > NCR) ? RSP_TIMEOUT : NCR;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] TIMEOUT_LD = TW'(RSP_TIMEOUT - 1);
  localparam logic [TW-1:0] GAP_LD     = TW'(NCR - 1);

  logic [2:0]    state;
  logic [5:0]    bitcnt;
  logic [46:0]   rx_sr;
  logic [6:0]    crc;
  logic [TW-1:0] timer;
  logic [39:0]   tx_sr;
  logic          tx_nocrc;
  logic [5:0]    txcnt;
  logic          tx_bit;
  logic          tx_fire;
  logic          rx_bad;
  logic          handshake;

  function automatic logic [6:0] crc7_next(input logic [6:0] c, input logic d);
    logic fb;
    fb = d ^ c[6];
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  // rx_sr holds bits 46..0 once all 47 post-start bits are in
  assign rx_bad    = ~rx_sr[46] | (rx_sr[7:1] != crc) | ~rx_sr[0];
  assign handshake = rsp_valid & rsp_ready;
  assign tx_fire   = ((state == S_GAP) && (timer == '0)) ||
                     ((state == S_TX) && (txcnt != 6'd48));

  always_comb begin
    tx_bit = 1'b1;
    if (txcnt < 6'd40)
      tx_bit = tx_sr[39];
    else if (txcnt < 6'd47)
      tx_bit = tx_nocrc | crc[6];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      bitcnt    <= '0;
      rx_sr     <= '0;
      crc       <= '0;
      timer     <= '0;
      tx_sr     <= '0;
      tx_nocrc  <= 1'b0;
      txcnt     <= '0;
      cmdo      <= 1'b1;
      cmdtn     <= 1'b1;
      cmd_valid <= 1'b0;
      cmd_index <= '0;
      cmd_arg   <= '0;
      cmd_err   <= 1'b0;
      rsp_ready <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!cmdi) begin
            state  <= S_RX;
            bitcnt <= 6'd1;
            rx_sr  <= '0;
            crc    <= '0;
          end
        end
        S_RX: begin
          if (bitcnt == 6'd48) begin
            cmd_valid <= 1'b1;
            cmd_index <= rx_sr[45:40];
            cmd_arg   <= rx_sr[39:8];
            cmd_err   <= rx_bad;
            if (rx_bad) begin
              state <= S_IDLE;
            end else begin
              state     <= S_WAIT_RSP;
              rsp_ready <= 1'b1;
              timer     <= TIMEOUT_LD;
            end
          end else begin
            rx_sr  <= {rx_sr[45:0], cmdi};
            bitcnt <= bitcnt + 6'd1;
            if (bitcnt <= 6'd39)
              crc <= crc7_next(crc, cmdi);
          end
        end
        S_WAIT_RSP: begin
          if (handshake) begin
            rsp_ready <= 1'b0;
            if (rsp_skip) begin
              state <= S_IDLE;
            end else begin
              state    <= S_GAP;
              tx_sr    <= {2'b00, rsp_index, rsp_arg};
              tx_nocrc <= rsp_nocrc;
              crc      <= '0;
              txcnt    <= '0;
              timer    <= GAP_LD;
            end
          end else if (timer == '0) begin
            rsp_ready <= 1'b0;
            state     <= S_IDLE;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        S_GAP: begin
          if (timer == '0)
            state <= S_TX;
          else
            timer <= timer - TW'(1);
        end
        S_TX: begin
          if (txcnt == 6'd48) begin
            cmdo  <= 1'b1;
            cmdtn <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      // the first response bit leaves on the same edge that ends the gap
      if (tx_fire) begin
        cmdo  <= tx_bit;
        cmdtn <= 1'b0;
        txcnt <= txcnt + 6'd1;
        if (txcnt < 6'd40) begin
          crc   <= crc7_next(crc, tx_bit);
          tx_sr <= {tx_sr[38:0], 1'b0};
        end else begin
          crc <= {crc[5:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_sdio_cmd_responder.sv
// Directed bench for sdio_cmd_responder: table of host frames plus hand-written
// response, timeout and mid-response reset sequences.
module tb_sdio_cmd_responder;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cmdi;
  logic        cmdo;
  logic        cmdtn;
  logic        cmd_valid;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        cmd_err;
  logic        rsp_ready;
  logic        rsp_valid;
  logic        rsp_skip;
  logic        rsp_nocrc;
  logic [5:0]  rsp_index;
  logic [31:0] rsp_arg;

  int n_vec = 0;
  int n_err = 0;
  int bad_drive = 0;
  logic tx_window = 1'b0;

  sdio_cmd_responder #(.NCR(2), .RSP_TIMEOUT(64)) dut (
    .clk(clk), .rstn(rstn), .cmdi(cmdi), .cmdo(cmdo), .cmdtn(cmdtn),
    .cmd_valid(cmd_valid), .cmd_index(cmd_index), .cmd_arg(cmd_arg),
    .cmd_err(cmd_err), .rsp_ready(rsp_ready), .rsp_valid(rsp_valid),
    .rsp_skip(rsp_skip), .rsp_nocrc(rsp_nocrc), .rsp_index(rsp_index),
    .rsp_arg(rsp_arg)
  );

  always #5 clk = ~clk;

  // line must never be driven outside an expected response window
  always @(negedge clk)
    if (rstn === 1'b1 && !tx_window && cmdtn !== 1'b1) bad_drive++;

  typedef struct {
    logic [47:0] frame;
    logic [5:0]  idx;
    logic [31:0] arg;
    logic        err;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic logic [47:0] mk(input logic [39:0] h, input logic e);
    return {h, crc7(h), e};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // sends a frame; returns just after edge s+48 with decode outputs checked
  task automatic do_cmd(input string tag, input logic [47:0] f, input logic [5:0] idx,
                        input logic [31:0] arg, input logic err);
    for (int i = 47; i >= 0; i--) begin
      cmdi = f[i];
      tick();
    end
    cmdi = 1'b1;
    chk({tag, "_valid_early"}, cmd_valid, 1'b0);
    tick();
    chk({tag, "_valid"}, cmd_valid, 1'b1);
    chk({tag, "_index"}, cmd_index, idx);
    chk({tag, "_arg"}, cmd_arg, arg);
    chk({tag, "_err"}, cmd_err, err);
    chk({tag, "_ready"}, rsp_ready, !err);
    chk({tag, "_cmdtn"}, cmdtn, 1'b1);
  endtask

  // handshake on the next edge h, then capture bits at h+2..h+49
  task automatic do_rsp(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                        input logic nocrc, output logic [47:0] cap);
    logic all_low;
    rsp_index = idx;
    rsp_arg   = arg;
    rsp_nocrc = nocrc;
    rsp_skip  = 1'b0;
    rsp_valid = 1'b1;
    tick();
    rsp_valid = 1'b0;
    chk({tag, "_ready_h"}, rsp_ready, 1'b0);
    chk({tag, "_cmdtn_h"}, cmdtn, 1'b1);
    tick();
    chk({tag, "_cmdtn_h1"}, cmdtn, 1'b1);
    tx_window = 1'b1;
    all_low = 1'b1;
    cap = '0;
    for (int k = 0; k < 48; k++) begin
      tick();
      cap = {cap[46:0], cmdo};
      if (cmdtn !== 1'b0) all_low = 1'b0;
    end
    chk({tag, "_drive_window"}, all_low, 1'b1);
    tick();
    chk({tag, "_cmdtn_end"}, cmdtn, 1'b1);
    chk({tag, "_cmdo_end"}, cmdo, 1'b1);
    tx_window = 1'b0;
  endtask

  initial begin
    logic [47:0] cap;
    logic        ok;

    vecs[0] = '{48'h48000001AA87, 6'd8, 32'h000001AA, 1'b0};
    vecs[1] = '{48'h48000001AA89, 6'd8, 32'h000001AA, 1'b1};
    vecs[2] = '{48'h400000000095, 6'd0, 32'h00000000, 1'b0};
    vecs[3] = '{mk(40'h7700000000, 1'b1), 6'd55, 32'h00000000, 1'b0};
    vecs[4] = '{mk(40'h5112345678, 1'b1), 6'd17, 32'h12345678, 1'b0};
    vecs[5] = '{mk(40'h05DEADBEEF, 1'b1), 6'd5, 32'hDEADBEEF, 1'b1};
    vecs[6] = '{mk(40'h7FFFFFFFFF, 1'b1), 6'd63, 32'hFFFFFFFF, 1'b0};
    vecs[7] = '{mk(40'h4C0000ABCD, 1'b0), 6'd12, 32'h0000ABCD, 1'b1};

    rstn = 1'b0; cmdi = 1'b1; rsp_valid = 1'b0; rsp_skip = 1'b0;
    rsp_nocrc = 1'b0; rsp_index = '0; rsp_arg = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmdo", cmdo, 1'b1);
    chk("rst_cmdtn", cmdtn, 1'b1);
    chk("rst_valid", cmd_valid, 1'b0);
    chk("rst_err", cmd_err, 1'b0);
    chk("rst_index", cmd_index, 6'd0);
    chk("rst_arg", cmd_arg, 32'd0);
    chk("rst_ready", rsp_ready, 1'b0);
    rstn = 1'b1;
    tick();

    // table: good frames are skipped immediately, next frame starts right after
    for (int i = 0; i < 8; i++) begin
      do_cmd($sformatf("v%0d", i), vecs[i].frame, vecs[i].idx, vecs[i].arg, vecs[i].err);
      if (!vecs[i].err) begin
        rsp_skip = 1'b1;
        rsp_valid = 1'b1;
      end
      tick();
      rsp_valid = 1'b0;
      rsp_skip = 1'b0;
      chk($sformatf("v%0d_valid_drop", i), cmd_valid, 1'b0);
      chk($sformatf("v%0d_ready_after", i), rsp_ready, 1'b0);
      chk($sformatf("v%0d_cmdtn_after", i), cmdtn, 1'b1);
    end

    // CMD8 response with CRC
    do_cmd("r8", 48'h48000001AA87, 6'd8, 32'h1AA, 1'b0);
    do_rsp("r8", 6'd8, 32'h1AA, 1'b0, cap);
    chk("r8_body", cap[47:8], 40'h08000001AA);
    chk("r8_crc", cap[7:1], crc7(40'h08000001AA));
    chk("r8_end", cap[0], 1'b1);

    // R3-style response back-to-back after TX
    do_cmd("r3", mk(40'h4500000000, 1'b1), 6'd5, 32'h0, 1'b0);
    do_rsp("r3", 6'h3F, 32'h80FF8000, 1'b1, cap);
    chk("r3_body", cap[47:8], 40'h3F80FF8000);
    chk("r3_crc", cap[7:1], 7'h7F);
    chk("r3_end", cap[0], 1'b1);

    // timeout: ready high through s+111, low at s+112
    do_cmd("to", 48'h48000001AA87, 6'd8, 32'h1AA, 1'b0);
    ok = 1'b1;
    for (int k = 49; k <= 111; k++) begin
      tick();
      if (rsp_ready !== 1'b1) ok = 1'b0;
    end
    chk("to_ready_held", ok, 1'b1);
    tick();
    chk("to_ready_fall", rsp_ready, 1'b0);
    chk("to_cmdtn", cmdtn, 1'b1);
    rsp_valid = 1'b1;
    tick();
    tick();
    rsp_valid = 1'b0;
    chk("to_late_valid_ready", rsp_ready, 1'b0);
    chk("to_late_valid_cmdtn", cmdtn, 1'b1);

    // reset while bit 20 of the response is on the line
    do_cmd("ab", 48'h48000001AA87, 6'd8, 32'h1AA, 1'b0);
    rsp_index = 6'd8; rsp_arg = 32'h1AA; rsp_nocrc = 1'b0; rsp_skip = 1'b0;
    rsp_valid = 1'b1;
    tick();
    rsp_valid = 1'b0;
    tick();
    tx_window = 1'b1;
    for (int k = 0; k <= 20; k++) tick();
    chk("ab_driving", cmdtn, 1'b0);
    #2;
    rstn = 1'b0;
    #1;
    tx_window = 1'b0;
    chk("ab_cmdtn_async", cmdtn, 1'b1);
    chk("ab_cmdo_async", cmdo, 1'b1);
    chk("ab_index_async", cmd_index, 6'd0);
    chk("ab_ready_async", rsp_ready, 1'b0);
    tick();
    rstn = 1'b1;
    do_cmd("ab_rec", mk(40'h5112345678, 1'b1), 6'd17, 32'h12345678, 1'b0);
    rsp_skip = 1'b1;
    rsp_valid = 1'b1;
    tick();
    rsp_valid = 1'b0;
    rsp_skip = 1'b0;
    chk("ab_rec_ready", rsp_ready, 1'b0);
    tick();

    chk("line_never_stray", bad_drive, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sdio_cmd_responder.md
# sdio_cmd_responder

Card-side responder for the SD/SDIO CMD line, the opposite end of the Zynq SDIO host master. It runs on the SD bus clock, deserializes 48-bit host command tokens from CMDI, and checks framing and CRC7. Each decoded command goes to card logic over a valid pulse. A 48-bit response supplied over a valid/ready handshake is then serialized back on CMDO/CMDTN after a programmable NCR gap. It sits in card models and the loopback test harness.

## Interface
- NCR, 2, CLK cycles between response handshake and response start bit (>=1)
- RSP_TIMEOUT, 64, cycles to wait for a response before abandoning (>=1)
- CLK  input  1  SD bus clock; CMD sampled and driven on rising edge
- RSTN  input  1  reset; asynchronous, active-low
- CMDI  input  1  CMD line from host
- CMDO  output  1  CMD line drive value
- CMDTN  output  1  CMD tri-state; 1=Hi-Z, 0=drive
- CMD_VALID  output  1  one-cycle pulse: command decoded
- CMD_INDEX  output  6  command index, held until next CMD_VALID
- CMD_ARG  output  32  command argument, held until next CMD_VALID
- CMD_ERR  output  1  qualifies CMD_VALID: CRC, transmission-bit or end-bit error
- RSP_READY  output  1  responder accepts a response
- RSP_VALID  input  1  response offered
- RSP_SKIP  input  1  with handshake: no response, for example CMD0
- RSP_NOCRC  input  1  with handshake: CRC field sent as 7'h7F (R3)
- RSP_INDEX  input  6  response index field
- RSP_ARG  input  32  response argument field

## Operation
- States: IDLE, RX, WAIT_RSP, GAP, TX.
- IDLE: CMDI=0 sampled, which is the start bit, moves to RX with bit count 1. CMDI is ignored in every other state.
- RX: shifts 47 more bits MSB-first. CRC7 (x^7+x^3+1, init 0) is computed over bits 47..8.
- After bit 0 (the end bit) is sampled:
  - Load CMD_INDEX and CMD_ARG.
  - Pulse CMD_VALID.
  - Set CMD_ERR if any of these hold: transmission bit != 1, received CRC != computed CRC, end bit != 1.
- After the end bit: CMD_ERR=1 goes to IDLE (no response); otherwise the state goes to WAIT_RSP.
- WAIT_RSP: RSP_READY=1. Handshake is RSP_VALID&RSP_READY.
  - RSP_SKIP=1 goes to IDLE.
  - Otherwise latch the frame {0,0,RSP_INDEX,RSP_ARG,CRC7 or 7'h7F,1} and go to GAP.
  - RSP_TIMEOUT cycles with no handshake go to IDLE silently.
- GAP: CMDTN=1 for NCR cycles, then go to TX.
- TX: CMDTN=0; the 48 frame bits are sent MSB-first. The response CRC7 is computed over the first 40 bits on the fly and shifted out after them. After bit 0, CMDTN=1 and CMDO=1, then the state returns to IDLE.
- RSTN low mid-frame, in either RX or TX, immediately aborts. The line is released in the same instant, asynchronously.

## Timing
- Reset values:
  - CMDO=1, CMDTN=1.
  - CMD_VALID=0, CMD_ERR=0, CMD_INDEX=0, CMD_ARG=0.
  - RSP_READY=0, state IDLE.
- Let the start bit be sampled at edge s. The end bit is sampled at edge s+47. CMD_VALID, CMD_ERR, CMD_INDEX and CMD_ARG are registered at edge s+48, and CMD_VALID drops at s+49.
- RSP_READY rises at edge s+48, same cycle as CMD_VALID, so a same-cycle response is allowed.
- Handshake at edge h:
  - RSP_READY=0 from edge h.
  - CMDTN=0 with CMDO=0 (start bit) at edge h+NCR.
  - Frame bit k is driven at edge h+NCR+k, for k=0..47.
  - CMDTN=1 at edge h+NCR+48.
- Timeout: with no handshake by edge s+48+RSP_TIMEOUT-1, RSP_READY=0 at edge s+48+RSP_TIMEOUT.
- Back-to-back: the first cycle after TX or abort is IDLE, and a start bit there is accepted.
- CMDTN never goes 0 outside TX; the CMDO value is don't-care while CMDTN=1, but is held at 1.

## Test plan
- Host frame 0x48_000001AA_87 (CMD8) -> CMD_VALID at s+48, CMD_INDEX=8, CMD_ARG=0x000001AA, CMD_ERR=0, RSP_READY=1.
- Same frame with its CRC byte changed to 0x89 -> CMD_VALID with CMD_ERR=1; RSP_READY stays 0; CMDTN stays 1.
- CMD8 response handshake with RSP_INDEX=8, RSP_ARG=0x1AA, NCR=2, at edge h -> CMDTN low over edges h+2..h+49. The captured 48 bits start 0x08000001AA, the CRC7 matches the bench model, and the end bit is 1.
- CMD0 frame 0x40_00000000_95 then handshake with RSP_SKIP=1 -> no CMDTN=0 cycle; next CMD accepted immediately.
- RSP_NOCRC=1 with RSP_INDEX=6'h3F and RSP_ARG=0x80FF8000 -> transmitted CRC field 7'h7F.
- No RSP_VALID for RSP_TIMEOUT=64 cycles -> RSP_READY falls at s+112 and the line stays released.
- RSTN pulsed low at bit 20 of TX -> CMDTN=1 asynchronously. After release the block is in IDLE and a new command decodes correctly.
